// File: rtl/snake_pkg.sv
// Shared screen/region geometry and scan FSM state encoding for fb_region_reader.
package snake_pkg;

   localparam int XSCREEN   = 160;
   localparam int YSCREEN   = 120;
   localparam int XDIM      = 10;
   localparam int YDIM      = 10;
   localparam int COLOR_W   = 3;
   localparam int FB_ADDR_W = 15;

   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE  = 2'd0;
   localparam fsm_state_t ST_SCAN  = 2'd1;
   localparam fsm_state_t ST_DRAIN = 2'd2;
   localparam fsm_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fb_ram.sv
// Shadow framebuffer: one write port, one synchronous read port (read-before-write).
module fb_ram #(
   parameter int DEPTH   = snake_pkg::XSCREEN * snake_pkg::YSCREEN,
   parameter int ADDR_W  = snake_pkg::FB_ADDR_W,
   parameter int COLOR_W = snake_pkg::COLOR_W
) (
   input  logic               Clock,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [COLOR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [COLOR_W-1:0] rdata
);

   // Contents start black at configuration and are never touched by reset.
   logic [COLOR_W-1:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge Clock) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/fb_region_reader.sv
// Scans an XDIM x YDIM region of a shadow framebuffer for a colour, reporting first hit and count.
// Optional macro FB_READER_EARLY_EXIT_EN stops the scan at the first matching pixel.
module fb_region_reader #(
   parameter int XSCREEN = snake_pkg::XSCREEN,
   parameter int YSCREEN = snake_pkg::YSCREEN,
   parameter int XDIM    = snake_pkg::XDIM,
   parameter int YDIM    = snake_pkg::YDIM,
   parameter int COLOR_W = snake_pkg::COLOR_W
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               plot,
   input  logic [7:0]         x,
   input  logic [6:0]         y,
   input  logic [COLOR_W-1:0] colour,
   input  logic               req,
   input  logic [7:0]         rx,
   input  logic [6:0]         ry,
   input  logic [COLOR_W-1:0] match_colour,
   output logic               busy,
   output logic               done,
   output logic               hit,
   output logic [7:0]         hit_x,
   output logic [6:0]         hit_y,
   output logic [6:0]         match_count
);

   import snake_pkg::*;

   function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [8:0] px, input logic [7:0] py);
      return FB_ADDR_W'(py) * FB_ADDR_W'(XSCREEN) + FB_ADDR_W'(px);
   endfunction

   function automatic logic in_screen(input logic [8:0] px, input logic [7:0] py);
      return (32'(px) < XSCREEN) && (32'(py) < YSCREEN);
   endfunction

   fsm_state_t         state;
   logic [7:0]         xc;
   logic [6:0]         yc;
   logic [7:0]         rx_l;
   logic [6:0]         ry_l;
   logic [COLOR_W-1:0] mcol_l;

   logic [8:0]           px_p0;
   logic [7:0]           py_p0;
   logic                 issue_p0;
   logic                 in_range_p0;
   logic                 last_p0;
   logic [FB_ADDR_W-1:0] raddr_p0;

   logic                 vld_p1;
   logic [7:0]           px_p1;
   logic [6:0]           py_p1;
   logic [COLOR_W-1:0]   rdata_p1;
   logic                 match_p1;

   logic                 wr_en;
   logic [FB_ADDR_W-1:0] wr_addr;

   assign wr_en   = plot && in_screen({1'b0, x}, {1'b0, y});
   assign wr_addr = pixel_addr({1'b0, x}, {1'b0, y});

   // Stage p0: widened coordinate sums so a region hanging off the screen never wraps.
   assign px_p0       = 9'(rx_l) + 9'(xc);
   assign py_p0       = 8'(ry_l) + 8'(yc);
   assign issue_p0    = (state == ST_SCAN);
   assign in_range_p0 = in_screen(px_p0, py_p0);
   assign raddr_p0    = in_range_p0 ? pixel_addr(px_p0, py_p0) : '0;
   assign last_p0     = (32'(xc) == XDIM - 1) && (32'(yc) == YDIM - 1);

   fb_ram #(
      .DEPTH   (XSCREEN * YSCREEN),
      .ADDR_W  (FB_ADDR_W),
      .COLOR_W (COLOR_W)
   ) u_ram (
      .Clock (Clock),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (colour),
      .raddr (raddr_p0),
      .rdata (rdata_p1)
   );

   // Stage p1: RAM data returns; only pixels issued by a live scan are evaluated.
   assign match_p1 = vld_p1 && ((state == ST_SCAN) || (state == ST_DRAIN)) && (rdata_p1 == mcol_l);

   always_ff @(posedge Clock) begin
      px_p1 <= px_p0[7:0];
      py_p1 <= py_p0[6:0];
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         xc          <= '0;
         yc          <= '0;
         rx_l        <= '0;
         ry_l        <= '0;
         mcol_l      <= '0;
         vld_p1      <= 1'b0;
         hit         <= 1'b0;
         hit_x       <= '0;
         hit_y       <= '0;
         match_count <= '0;
      end else begin
         vld_p1 <= issue_p0 && in_range_p0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state       <= ST_SCAN;
                  rx_l        <= rx;
                  ry_l        <= ry;
                  mcol_l      <= match_colour;
                  xc          <= '0;
                  yc          <= '0;
                  hit         <= 1'b0;
                  hit_x       <= '0;
                  hit_y       <= '0;
                  match_count <= '0;
               end
            end
            ST_SCAN: begin
               if (last_p0) begin
                  state <= ST_DRAIN;
                  xc    <= '0;
                  yc    <= '0;
               end else if (32'(xc) == XDIM - 1) begin
                  xc <= '0;
                  yc <= yc + 7'd1;
               end else begin
                  xc <= xc + 8'd1;
               end
`ifdef FB_READER_EARLY_EXIT_EN
               // The pixel issued alongside the match is still in flight; DONE discards it.
               if (match_p1) state <= ST_DONE;
`endif
            end
            ST_DRAIN: state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
         if (match_p1) begin
            match_count <= match_count + 7'd1;
            if (!hit) begin
               hit   <= 1'b1;
               hit_x <= px_p1;
               hit_y <= py_p1;
            end
         end
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fb_region_reader.sv
// Scoreboard bench for fb_region_reader: a reference framebuffer model predicts each scan result.
module tb_fb_region_reader;

   localparam int XS   = 160;
   localparam int YS   = 120;
   localparam int XDIM = 10;
   localparam int YDIM = 10;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       plot = 1'b0;
   logic [7:0] x = '0;
   logic [6:0] y = '0;
   logic [2:0] colour = '0;
   logic       req = 1'b0;
   logic [7:0] rx = '0;
   logic [6:0] ry = '0;
   logic [2:0] match_colour = '0;
   logic       busy, done, hit;
   logic [7:0] hit_x;
   logic [6:0] hit_y;
   logic [6:0] match_count;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string tag;
      bit    hit;
      int    hx;
      int    hy;
      int    cnt;
      int    lat;
   } exp_t;

   exp_t     sb[$];
   bit [2:0] fb [XS*YS];

   fb_region_reader dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .plot         (plot),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .req          (req),
      .rx           (rx),
      .ry           (ry),
      .match_colour (match_colour),
      .busy         (busy),
      .done         (done),
      .hit          (hit),
      .hit_x        (hit_x),
      .hit_y        (hit_y),
      .match_count  (match_count)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic exp_t model_scan(input string tag, input int sx, input int sy, input int mc);
      exp_t e;
      e.tag = tag; e.hit = 0; e.hx = 0; e.hy = 0; e.cnt = 0; e.lat = XDIM*YDIM + 2;
      for (int yc = 0; yc < YDIM; yc++) begin
         for (int xc = 0; xc < XDIM; xc++) begin
            int px;
            int py;
            px = sx + xc;
            py = sy + yc;
            if (px < XS && py < YS && int'(fb[py*XS + px]) == mc) begin
               if (!e.hit) begin
                  e.hit = 1; e.hx = px; e.hy = py;
`ifdef FB_READER_EARLY_EXIT_EN
                  e.lat = yc*XDIM + xc + 1 + 2;
`endif
               end
               e.cnt++;
            end
         end
      end
`ifdef FB_READER_EARLY_EXIT_EN
      if (e.hit) e.cnt = 1;
`endif
      return e;
   endfunction

   task automatic do_plot(input int px, input int py, input int c);
      @(negedge Clock);
      plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(c);
      @(negedge Clock);
      plot = 1'b0;
      if (px < XS && py < YS) fb[py*XS + px] = 3'(c);
   endtask

   task automatic start_scan(input string tag, input int sx, input int sy, input int mc);
      sb.push_back(model_scan(tag, sx, sy, mc));
      @(negedge Clock);
      req = 1'b1; rx = 8'(sx); ry = 7'(sy); match_colour = 3'(mc);
      @(posedge Clock);
      #1 req = 1'b0;
   endtask

   // act 1: stray req at cycle n; act 2: plots (0,0)=6 and (9,9)=6 at cycles n, n+1.
   task automatic wait_done(input int act, input int n);
      exp_t e;
      int   cyc = 0;
      int   extra = 0;
      bit   seen = 0;
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      while (!seen && cyc < 400) begin
         @(negedge Clock);
         cyc++;
         if (cyc == 1) chk({e.tag, "_busy"}, 32'(busy), 1);
         if (act == 1 && cyc == n) begin req = 1'b1; rx = 8'd0; ry = 7'd0; end
         if (act == 1 && cyc == n + 1) req = 1'b0;
         if (act == 2 && cyc == n) begin plot = 1'b1; x = 8'd0; y = 7'd0; colour = 3'd6; end
         if (act == 2 && cyc == n + 1) begin x = 8'd9; y = 7'd9; end
         if (act == 2 && cyc == n + 2) plot = 1'b0;
         if (done) seen = 1;
      end
      req = 1'b0;
      plot = 1'b0;
      if (!seen) begin
         chk({e.tag, "_done_timeout"}, 0, 1);
         return;
      end
      chk({e.tag, "_latency"}, 32'(cyc), 32'(e.lat));
      chk({e.tag, "_hit"}, 32'(hit), 32'(e.hit));
      chk({e.tag, "_hit_x"}, 32'(hit_x), 32'(e.hx));
      chk({e.tag, "_hit_y"}, 32'(hit_y), 32'(e.hy));
      chk({e.tag, "_count"}, 32'(match_count), 32'(e.cnt));
      repeat (4) begin
         @(negedge Clock);
         if (done) extra++;
      end
      chk({e.tag, "_extra_done"}, 32'(extra), 0);
      chk({e.tag, "_busy_end"}, 32'(busy), 0);
      chk({e.tag, "_count_hold"}, 32'(match_count), 32'(e.cnt));
   endtask

   initial begin
      int extra;
      int rc;
      repeat (3) @(negedge Clock);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_hit", 32'(hit), 0);
      chk("rst_hit_x", 32'(hit_x), 0);
      chk("rst_hit_y", 32'(hit_y), 0);
      chk("rst_count", 32'(match_count), 0);
      Reset = 1'b0;

      start_scan("empty", 80, 60, 4);
      wait_done(0, 0);

      do_plot(85, 65, 4);
      do_plot(89, 69, 4);
      start_scan("two_hits", 80, 60, 4);
      wait_done(0, 0);

      start_scan("corner", 155, 115, 0);
      wait_done(0, 0);

      // Abort a scan with reset at cycle 40.
      @(negedge Clock);
      req = 1'b1; rx = 8'd80; ry = 7'd60; match_colour = 3'd4;
      @(posedge Clock);
      #1 req = 1'b0;
      repeat (40) @(negedge Clock);
      Reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_count", 32'(match_count), 0);
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      extra = 0;
      repeat (120) begin
         @(negedge Clock);
         if (done) extra++;
      end
      chk("abort_no_done", 32'(extra), 0);
      start_scan("after_abort", 80, 60, 4);
      wait_done(0, 0);

      start_scan("stray_req", 120, 0, 7);
      wait_done(1, 20);

      do_plot(200, 10, 5);
      start_scan("oor_plot", 150, 10, 5);
      wait_done(0, 0);
      start_scan("oor_alias", 40, 11, 5);
      wait_done(0, 0);

      // (9,9) is written before it is read, (0,0) after it has already been read.
      fb[9*XS + 9] = 3'd6;
      start_scan("wr_during", 0, 0, 6);
      wait_done(2, 50);
      fb[0] = 3'd6;
      start_scan("wr_after", 0, 0, 6);
      wait_done(0, 0);

      for (int r = 0; r < 2; r++) begin
         repeat (30) do_plot(20 + int'($urandom_range(9)), 30 + int'($urandom_range(9)),
                             int'($urandom_range(7)));
         rc = int'($urandom_range(7));
         start_scan($sformatf("rand%0d", r), 20, 30, rc);
         wait_done(0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
